// File: rtl/wts_stereo_mix_accumulator.sv
`default_nettype none
//==============================================================================
// Module   : wts_stereo_mix_accumulator
// Purpose  : Time-division stereo mixer. One signed voice sample arrives per
//            clock across SLOTS slots per frame. Each sample is routed to the
//            left and/or right side, attenuated by an arithmetic right shift,
//            and summed at full precision. At the end of each frame the sums
//            are saturated to OUT_W, optionally converted to offset-binary,
//            and presented as one stereo sample with a one-clock valid strobe.
//
// Ports    : clk, nreset        - clock, asynchronous active-low reset
//            slot_start         - current cycle is slot 0 (realigns frame)
//            sample_valid       - sample_in is valid for the current slot
//            sample_in          - signed voice sample, SAMPLE_W bits
//            enable[1:0]        - [1] route to left, [0] route to right
//            att_l, att_r       - per-side right-shift attenuation, 0..7
//            left_out/right_out - mixed stereo sample, OUT_W bits
//            out_valid          - one-clock pulse when outputs update
//            clip_l, clip_r     - sticky saturation flags
//            clip_clear         - clears clip flags (a new clip wins)
//
// Revision : 1.0 - initial release
//==============================================================================
module wts_stereo_mix_accumulator #(
    parameter int SLOTS      = 12,
    parameter int SAMPLE_W   = 8,
    parameter int OUT_W      = 12,
    parameter int OFFSET_BIN = 1
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                slot_start,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [1:0]          enable,
    input  logic [2:0]          att_l,
    input  logic [2:0]          att_r,
    output logic [OUT_W-1:0]    left_out,
    output logic [OUT_W-1:0]    right_out,
    output logic                out_valid,
    output logic                clip_l,
    output logic                clip_r,
    input  logic                clip_clear
);

    localparam int c_cnt_w = $clog2(SLOTS);
    // One extra bit beyond SAMPLE_W + log2(SLOTS) keeps the full-frame sum
    // from ever wrapping.
    localparam int c_acc_w = SAMPLE_W + $clog2(SLOTS) + 1;

    localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(SLOTS - 1);
    localparam logic [OUT_W-1:0]   c_msb       = {1'b1, {(OUT_W-1){1'b0}}};
    // XOR mask applied after saturation; also the reset value of the outputs
    // (mid-scale in offset-binary, zero in two's complement).
    localparam logic [OUT_W-1:0]   c_out_xor   = (OFFSET_BIN != 0) ? c_msb : '0;

    logic [c_cnt_w-1:0]         r_slot;
    logic signed [c_acc_w-1:0]  r_acc_l;
    logic signed [c_acc_w-1:0]  r_acc_r;
    logic [OUT_W-1:0]           r_left;
    logic [OUT_W-1:0]           r_right;
    logic                       r_valid;
    logic                       r_clip_l;
    logic                       r_clip_r;

    logic [c_cnt_w-1:0]         w_slot;
    logic                       w_first;
    logic                       w_last;
    logic signed [SAMPLE_W-1:0] w_shift_l;
    logic signed [SAMPLE_W-1:0] w_shift_r;
    logic signed [c_acc_w-1:0]  w_contrib_l;
    logic signed [c_acc_w-1:0]  w_contrib_r;
    logic signed [c_acc_w-1:0]  w_sum_l;
    logic signed [c_acc_w-1:0]  w_sum_r;
    logic [OUT_W-1:0]           w_sat_l;
    logic [OUT_W-1:0]           w_sat_r;
    logic                       w_ovf_l;
    logic                       w_ovf_r;

    // slot_start overrides the counter, so a start on the counter's last slot
    // is treated as slot 0 and the truncated frame never produces output.
    assign w_slot  = slot_start ? '0 : r_slot;
    assign w_first = (w_slot == '0);
    assign w_last  = (w_slot == c_last_slot);

    assign w_shift_l = $signed(sample_in) >>> att_l;
    assign w_shift_r = $signed(sample_in) >>> att_r;

    assign w_contrib_l = (sample_valid && enable[1]) ? c_acc_w'(w_shift_l) : '0;
    assign w_contrib_r = (sample_valid && enable[0]) ? c_acc_w'(w_shift_r) : '0;

    // Slot 0 starts a fresh sum, discarding any partial frame left behind.
    assign w_sum_l = (w_first ? '0 : r_acc_l) + w_contrib_l;
    assign w_sum_r = (w_first ? '0 : r_acc_r) + w_contrib_r;

    generate
        if (OUT_W >= c_acc_w) begin : g_no_sat
            assign w_sat_l = OUT_W'(w_sum_l);
            assign w_sat_r = OUT_W'(w_sum_r);
            assign w_ovf_l = 1'b0;
            assign w_ovf_r = 1'b0;
        end else begin : g_sat
            localparam logic signed [c_acc_w-1:0] c_max =
                {{(c_acc_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [c_acc_w-1:0] c_min =
                {{(c_acc_w-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

            always_comb begin
                w_ovf_l = 1'b0;
                w_sat_l = w_sum_l[OUT_W-1:0];
                if (w_sum_l > c_max) begin
                    w_ovf_l = 1'b1;
                    w_sat_l = c_max[OUT_W-1:0];
                end else if (w_sum_l < c_min) begin
                    w_ovf_l = 1'b1;
                    w_sat_l = c_min[OUT_W-1:0];
                end
            end

            always_comb begin
                w_ovf_r = 1'b0;
                w_sat_r = w_sum_r[OUT_W-1:0];
                if (w_sum_r > c_max) begin
                    w_ovf_r = 1'b1;
                    w_sat_r = c_max[OUT_W-1:0];
                end else if (w_sum_r < c_min) begin
                    w_ovf_r = 1'b1;
                    w_sat_r = c_min[OUT_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_slot   <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_left   <= c_out_xor;
            r_right  <= c_out_xor;
            r_valid  <= 1'b0;
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (w_last) begin
                r_slot  <= '0;
                r_acc_l <= '0;
                r_acc_r <= '0;
                r_left  <= w_sat_l ^ c_out_xor;
                r_right <= w_sat_r ^ c_out_xor;
            end else begin
                r_slot  <= w_slot + c_cnt_w'(1);
                r_acc_l <= w_sum_l;
                r_acc_r <= w_sum_r;
            end
            // A clip event on the frame's last slot beats a coincident clear.
            r_clip_l <= (w_last & w_ovf_l) | (r_clip_l & ~clip_clear);
            r_clip_r <= (w_last & w_ovf_r) | (r_clip_r & ~clip_clear);
        end
    end

    assign left_out  = r_left;
    assign right_out = r_right;
    assign out_valid = r_valid;
    assign clip_l    = r_clip_l;
    assign clip_r    = r_clip_r;

endmodule
`default_nettype wire

// File: tb/tb_wts_stereo_mix_accumulator.sv
`default_nettype none
//==============================================================================
// Module   : tb_wts_stereo_mix_accumulator
// Purpose  : Self-checking bench for wts_stereo_mix_accumulator. Two DUTs see
//            the same stimulus: default parameters (12-bit offset-binary) and
//            OUT_W=10 two's complement (saturating). A reference model queues
//            expected frame results with their expected arrival cycle.
// Revision : 1.0 - initial release
//==============================================================================
module tb_wts_stereo_mix_accumulator;

    localparam int SLOTS = 12;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        slot_start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_in = '0;
    logic [1:0]  enable = '0;
    logic [2:0]  att_l = '0;
    logic [2:0]  att_r = '0;
    logic        clip_clear = 1'b0;

    logic [11:0] a_left, a_right;
    logic        a_valid, a_clip_l, a_clip_r;
    logic [9:0]  b_left, b_right;
    logic        b_valid, b_clip_l, b_clip_r;

    wts_stereo_mix_accumulator #(.SLOTS(12), .SAMPLE_W(8), .OUT_W(12), .OFFSET_BIN(1)) dut_a (
        .clk(clk), .nreset(nreset), .slot_start(slot_start), .sample_valid(sample_valid),
        .sample_in(sample_in), .enable(enable), .att_l(att_l), .att_r(att_r),
        .left_out(a_left), .right_out(a_right), .out_valid(a_valid),
        .clip_l(a_clip_l), .clip_r(a_clip_r), .clip_clear(clip_clear));

    wts_stereo_mix_accumulator #(.SLOTS(12), .SAMPLE_W(8), .OUT_W(10), .OFFSET_BIN(0)) dut_b (
        .clk(clk), .nreset(nreset), .slot_start(slot_start), .sample_valid(sample_valid),
        .sample_in(sample_in), .enable(enable), .att_l(att_l), .att_r(att_r),
        .left_out(b_left), .right_out(b_right), .out_valid(b_valid),
        .clip_l(b_clip_l), .clip_r(b_clip_r), .clip_clear(clip_clear));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0][15:0] l;
        logic [1:0][15:0] r;
        int               c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, shared accumulation; per-DUT clip flags.
    int               m_cnt = 0;
    int               m_acc_l = 0;
    int               m_acc_r = 0;
    logic [1:0]       mcl = '0;
    logic [1:0]       mcr = '0;
    logic [1:0][15:0] last_l;
    logic [1:0][15:0] last_r;
    int               ow [2] = '{12, 10};
    bit               ob [2] = '{1'b1, 1'b0};

    logic [1:0][15:0] obs_l, obs_r;
    logic [1:0]       obs_v, obs_cl, obs_cr;
    assign obs_l  = {6'b0, b_left, 4'b0, a_left};
    assign obs_r  = {6'b0, b_right, 4'b0, a_right};
    assign obs_v  = {b_valid, a_valid};
    assign obs_cl = {b_clip_l, a_clip_l};
    assign obs_cr = {b_clip_r, a_clip_r};

    function automatic void sat(input int sum, input int w, input bit offs,
                                output logic [15:0] v, output bit clip);
        int mx, mn, t;
        mx   = (1 << (w - 1)) - 1;
        mn   = -(1 << (w - 1));
        t    = sum;
        clip = 1'b0;
        if (sum > mx) begin t = mx; clip = 1'b1; end
        else if (sum < mn) begin t = mn; clip = 1'b1; end
        v = 16'(t) & ((16'd1 << w) - 16'd1);
        if (offs) v = v ^ (16'd1 << (w - 1));
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_acc_l = 0;
        m_acc_r = 0;
        mcl     = '0;
        mcr     = '0;
        q.delete();
        last_l  = {16'h0000, 16'h0800};
        last_r  = {16'h0000, 16'h0800};
    endtask

    // Drive one slot at a negedge, advance the model, return at next negedge.
    task automatic drive(input bit st, input bit v, input int s, input bit [1:0] en,
                         input int al, input int ar, input bit clr);
        int slot, cl, cr, sl, sr;
        exp_t e;
        logic [15:0] vv;
        bit c;
        slot_start   = st;
        sample_valid = v;
        sample_in    = 8'(s);
        enable       = en;
        att_l        = 3'(al);
        att_r        = 3'(ar);
        clip_clear   = clr;
        slot = st ? 0 : m_cnt;
        cl = (v && en[1]) ? (s >>> al) : 0;
        cr = (v && en[0]) ? (s >>> ar) : 0;
        sl = (slot == 0 ? 0 : m_acc_l) + cl;
        sr = (slot == 0 ? 0 : m_acc_r) + cr;
        if (slot == SLOTS - 1) begin
            for (int k = 0; k < 2; k++) begin
                sat(sl, ow[k], ob[k], vv, c);
                e.l[k] = vv;
                mcl[k] = c | (mcl[k] & ~clr);
                sat(sr, ow[k], ob[k], vv, c);
                e.r[k] = vv;
                mcr[k] = c | (mcr[k] & ~clr);
            end
            e.c = cyc + 1;
            q.push_back(e);
            m_acc_l = 0;
            m_acc_r = 0;
            m_cnt   = 0;
        end else begin
            if (clr) begin mcl = '0; mcr = '0; end
            m_acc_l = sl;
            m_acc_r = sr;
            m_cnt   = slot + 1;
        end
        @(negedge clk);
    endtask

    task automatic frame(input bit st, input int s, input bit [1:0] en,
                         input int al, input int ar);
        for (int i = 0; i < SLOTS; i++)
            drive(st && (i == 0), 1'b1, s, en, al, ar, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        assert ({a_left, a_right} === {12'h800, 12'h800}) else begin
            errors++; $error("FAIL %s a_outputs got %h/%h exp 800/800", tag, a_left, a_right);
        end
        checks++;
        assert ({b_left, b_right} === {10'h000, 10'h000}) else begin
            errors++; $error("FAIL %s b_outputs got %h/%h exp 000/000", tag, b_left, b_right);
        end
        checks++;
        assert ({a_valid, b_valid, a_clip_l, a_clip_r, b_clip_l, b_clip_r} === 6'b0) else begin
            errors++; $error("FAIL %s valid_clip got %b%b%b%b%b%b exp 000000", tag,
                             a_valid, b_valid, a_clip_l, a_clip_r, b_clip_l, b_clip_r);
        end
    endtask

    // Output monitor: pops the scoreboard when a result is due, otherwise
    // requires the outputs to hold their last value.
    always @(posedge clk) begin
        exp_t e;
        bit   have;
        #2;
        if (nreset) begin
            have = 1'b0;
            if (q.size() > 0 && q[0].c <= cyc) begin
                e = q.pop_front();
                have = 1'b1;
                last_l = e.l;
                last_r = e.r;
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                assert (obs_v[k] === have) else begin
                    errors++; $error("FAIL out_valid dut%0d cyc %0d got %b exp %b", k, cyc, obs_v[k], have);
                end
                checks++;
                assert ({obs_l[k], obs_r[k]} === {last_l[k], last_r[k]}) else begin
                    errors++; $error("FAIL outputs dut%0d cyc %0d got %h/%h exp %h/%h", k, cyc,
                                     obs_l[k], obs_r[k], last_l[k], last_r[k]);
                end
                checks++;
                assert ({obs_cl[k], obs_cr[k]} === {mcl[k], mcr[k]}) else begin
                    errors++; $error("FAIL clip dut%0d cyc %0d got %b%b exp %b%b", k, cyc,
                                     obs_cl[k], obs_cr[k], mcl[k], mcr[k]);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        nreset = 1'b1;

        // Full-scale positive into both sides: A -> DF4, B clips to 1FF.
        frame(1'b1, 127, 2'b11, 0, 0);
        // Two frames of -128 left only, counter wraps without slot_start.
        frame(1'b0, -128, 2'b10, 0, 0);
        frame(1'b0, -128, 2'b10, 0, 0);
        // Attenuation: 64>>2 = 16 per slot on left, 64>>7 = 0 on right.
        frame(1'b1, 64, 2'b11, 2, 7);
        // -1 shifted stays -1: twelve slots give -12.
        frame(1'b1, -1, 2'b11, 3, 3);

        // Idle frame with clip_clear pulse mid-frame clears the sticky flags.
        for (int i = 0; i < SLOTS; i++)
            drive(i == 0, 1'b0, 0, 2'b00, 0, 0, i == 3);
        // Clipping frame with clip_clear on its last slot: set wins.
        for (int i = 0; i < SLOTS; i++)
            drive(i == 0, 1'b1, 127, 2'b11, 0, 0, i == SLOTS - 1);

        // Truncation at slot 7: partial frame discarded.
        for (int i = 0; i < 7; i++) drive(i == 0, 1'b1, 100, 2'b11, 0, 0, 1'b0);
        frame(1'b1, 5, 2'b11, 0, 1);
        // slot_start on the counter's last slot: no output for that frame.
        for (int i = 0; i < SLOTS - 1; i++) drive(i == 0, 1'b1, 90, 2'b11, 0, 0, 1'b0);
        frame(1'b1, -7, 2'b01, 0, 0);

        // A few randomised frames.
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < SLOTS; i++)
                drive(i == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                      2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), 1'b0);

        // Asynchronous reset mid-frame with non-zero accumulators.
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, 100, 2'b11, 0, 0, 1'b0);
        #2 nreset = 1'b0;
        #1 check_reset_state("mid_reset");
        model_reset();
        repeat (2) @(negedge clk);
        slot_start = 1'b0; sample_valid = 1'b0; clip_clear = 1'b0;
        nreset = 1'b1;
        // Counter restarted at 0: frame holds only post-reset samples (120).
        frame(1'b0, 10, 2'b11, 0, 0);
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b0);

        checks++;
        assert (q.size() == 0) else begin
            errors++; $error("FAIL pending_results got %0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
